// File: rtl/de_selector_14_pkg.sv
// Shared types and select encodings for the de_selector_14 registered 1-to-4 demultiplexer.
package de_selector_14_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_Z0 = 2'd0;
  localparam sel_t SEL_Z1 = 2'd1;
  localparam sel_t SEL_Z2 = 2'd2;
  localparam sel_t SEL_Z3 = 2'd3;

endpackage : de_selector_14_pkg

// File: rtl/de_selector_14_dec.sv
// Combinational 2-to-4 one-hot decoder; bit k is set when the select equals k.
module de_selector_14_dec
  import de_selector_14_pkg::*;
(
  input  sel_t       sel_i,
  output logic [3:0] onehot_o
);

  // Decode the select into one-hot form
  always_comb begin
    onehot_o = 4'b0000;
    case (sel_i)
      SEL_Z0:  onehot_o = 4'b0001;
      SEL_Z1:  onehot_o = 4'b0010;
      SEL_Z2:  onehot_o = 4'b0100;
      SEL_Z3:  onehot_o = 4'b1000;
      default: onehot_o = 4'b0000;
    endcase
  end

endmodule : de_selector_14_dec

// File: rtl/de_selector_14.sv
// Registered 1-to-4 demultiplexer: routes iC to oZ[{iS1,iS0}], zeros elsewhere, one cycle latency.
// Optional update enable port iEn is built in when DE_SELECTOR_14_ENABLE_EN is defined.
module de_selector_14
  import de_selector_14_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iC,
  input  logic             iS1,
  input  logic             iS0,
`ifdef DE_SELECTOR_14_ENABLE_EN
  input  logic             iEn,
`endif
  output logic [WIDTH-1:0] oZ0,
  output logic [WIDTH-1:0] oZ1,
  output logic [WIDTH-1:0] oZ2,
  output logic [WIDTH-1:0] oZ3
);

  sel_t             sel_s;
  logic [3:0]       onehot_s;
  logic [WIDTH-1:0] z_d [4];
  logic [WIDTH-1:0] z_q [4];

  assign sel_s = {iS1, iS0};

  de_selector_14_dec u_dec (
    .sel_i    (sel_s),
    .onehot_o (onehot_s)
  );

  // Mask the data onto the selected lane only
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      z_d[k] = iC & {WIDTH{onehot_s[k]}};
    end
  end

  // Output registers: reset dominates, then (optional) enable, then load
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < 4; k++) begin
        z_q[k] <= {WIDTH{1'b0}};
      end
`ifdef DE_SELECTOR_14_ENABLE_EN
    end else if (iEn) begin
`else
    end else begin
`endif
      for (int k = 0; k < 4; k++) begin
        z_q[k] <= z_d[k];
      end
    end
  end

  assign oZ0 = z_q[0];
  assign oZ1 = z_q[1];
  assign oZ2 = z_q[2];
  assign oZ3 = z_q[3];

endmodule : de_selector_14

// File: tb/tb_de_selector_14.sv
// Scoreboard bench for de_selector_14 (WIDTH=8): directed cases then random traffic vs a reference model.
module tb_de_selector_14;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] c;
  logic         s1;
  logic         s0;
  logic         en;
  logic [W-1:0] z0, z1, z2, z3;

  int checks = 0;
  int fails  = 0;

  logic [4*W-1:0] exp_q [$];
  logic [W-1:0]   model_z [4];

  de_selector_14 #(.WIDTH(W)) dut (
    .iClk (clk),
    .iRst (rst),
    .iC   (c),
    .iS1  (s1),
    .iS0  (s0),
`ifdef DE_SELECTOR_14_ENABLE_EN
    .iEn  (en),
`endif
    .oZ0  (z0),
    .oZ1  (z1),
    .oZ2  (z2),
    .oZ3  (z3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and record what the outputs must show after the next edge
  task automatic step(input logic r, input logic [W-1:0] d, input int sel, input logic e);
    logic loads;
    @(negedge clk);
    rst = r;
    c   = d;
    s1  = sel[1];
    s0  = sel[0];
    en  = e;
`ifdef DE_SELECTOR_14_ENABLE_EN
    loads = e;
`else
    loads = 1'b1;
`endif
    if (r) begin
      for (int k = 0; k < 4; k++) model_z[k] = '0;
    end else if (loads) begin
      for (int k = 0; k < 4; k++) model_z[k] = (k == sel) ? d : '0;
    end
    exp_q.push_back({model_z[3], model_z[2], model_z[1], model_z[0]});
  endtask

  // Monitor: one expected entry per clock edge after stimulus began
  initial begin
    logic [4*W-1:0] got;
    logic [4*W-1:0] exp;
    int nz;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {z3, z2, z1, z0};
        checks++;
        if (got !== exp) begin
          fails++;
          $display("FAIL outputs t=%0t: got z3..z0=%h expected %h", $time, got, exp);
        end
        nz = (z0 != '0) + (z1 != '0) + (z2 != '0) + (z3 != '0);
        checks++;
        if (nz > 1) begin
          fails++;
          $display("FAIL onehot t=%0t: %0d outputs non-zero, expected at most 1", $time, nz);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; c = '0; s1 = 1'b0; s0 = 1'b0; en = 1'b1;

    // reset with iC=1, sel=2, then release
    step(1'b1, 8'h01, 2, 1'b1);
    step(1'b0, 8'h01, 2, 1'b1);

    // zero data sweep
    for (int s = 0; s < 4; s++) step(1'b0, 8'h00, s, 1'b1);
    // one data sweep
    for (int s = 0; s < 4; s++) step(1'b0, 8'h01, s, 1'b1);

    // mid-stream reset on sel=3
    step(1'b0, 8'h01, 3, 1'b1);
    step(1'b0, 8'h01, 3, 1'b1);
    step(1'b1, 8'h01, 3, 1'b1);
    step(1'b0, 8'h01, 3, 1'b1);

    // full-width pattern
    step(1'b0, 8'hA5, 1, 1'b1);
    step(1'b0, 8'hA5, 0, 1'b1);
    step(1'b0, 8'hFF, 3, 1'b1);

`ifdef DE_SELECTOR_14_ENABLE_EN
    // enable holds outputs while low; reset still overrides it
    step(1'b0, 8'h01, 0, 1'b1);
    step(1'b0, 8'h01, 3, 1'b0);
    step(1'b0, 8'h5A, 2, 1'b0);
    step(1'b0, 8'h01, 3, 1'b1);
    step(1'b1, 8'h01, 3, 1'b0);
    step(1'b0, 8'h77, 1, 1'b0);
`endif

    // random traffic with occasional reset and enable drops
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), W'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_de_selector_14
